// File: rtl/light_pattern_shifter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | light_pattern_shifter_if                                                 |
// | Control/pattern bundle between a controller and the LED pattern engine.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface light_pattern_shifter_if #(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 4
);
  logic               ena;
  logic [1:0]         mode;
  logic               l_rn;
  logic               fill;
  logic [PRESC_W-1:0] div;
  logic               load;
  logic [WIDTH-1:0]   load_data;
  logic [WIDTH-1:0]   out;
  logic               step;
  logic               edge_hit;

  modport master (
    output ena, mode, l_rn, fill, div, load, load_data,
    input  out, step, edge_hit
  );

  modport slave (
    input  ena, mode, l_rn, fill, div, load, load_data,
    output out, step, edge_hit
  );
endinterface
`default_nettype wire

// File: rtl/light_pattern_shifter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | light_pattern_shifter                                                    |
// | WIDTH-bit LED pattern engine: hold/rotate/shift/bounce per prescaler     |
// | period. Bounce mode is built only when LPS_BOUNCE_EN is defined.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module light_pattern_shifter #(
  parameter int               WIDTH     = 8,
  parameter int               PRESC_W   = 4,
  parameter logic [WIDTH-1:0] RESET_PAT = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic                    clk,
  input  logic                    nrst,
  light_pattern_shifter_if.slave  bus
);

  localparam logic [1:0] c_MODE_HOLD  = 2'b00;
  localparam logic [1:0] c_MODE_SHIFT = 2'b10;

  logic [WIDTH-1:0]   r_out;
  logic [PRESC_W-1:0] r_cnt;
  logic               r_step;
  logic               w_step;
  logic [WIDTH-1:0]   w_next;

  // >= rather than == so that shrinking div below the running count steps at once
  assign w_step = bus.ena && (r_cnt >= bus.div);

`ifdef LPS_BOUNCE_EN
  logic r_dir;
  logic r_edge;
  logic w_edge;
  logic w_dir_next;
`endif

  always_comb begin
    w_next = r_out;
`ifdef LPS_BOUNCE_EN
    w_edge     = 1'b0;
    w_dir_next = r_dir;
`endif
    case (bus.mode)
      c_MODE_HOLD: w_next = r_out;
      c_MODE_SHIFT: begin
        if (bus.l_rn) w_next = {r_out[WIDTH-2:0], bus.fill};
        else          w_next = {bus.fill, r_out[WIDTH-1:1]};
      end
`ifdef LPS_BOUNCE_EN
      2'b11: begin
        if (r_dir && r_out[WIDTH-1]) begin
          w_next     = {1'b0, r_out[WIDTH-1:1]};
          w_dir_next = 1'b0;
          w_edge     = 1'b1;
        end else if (!r_dir && r_out[0]) begin
          w_next     = {r_out[WIDTH-2:0], 1'b0};
          w_dir_next = 1'b1;
          w_edge     = 1'b1;
        end else if (r_dir) begin
          w_next = {r_out[WIDTH-2:0], 1'b0};
        end else begin
          w_next = {1'b0, r_out[WIDTH-1:1]};
        end
      end
`endif
      // Rotate; without bounce support mode 11 lands here too
      default: begin
        if (bus.l_rn) w_next = {r_out[WIDTH-2:0], r_out[WIDTH-1]};
        else          w_next = {r_out[0], r_out[WIDTH-1:1]};
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_out  <= RESET_PAT;
      r_cnt  <= '0;
      r_step <= 1'b0;
`ifdef LPS_BOUNCE_EN
      r_dir  <= 1'b1;
      r_edge <= 1'b0;
`endif
    end else if (bus.load) begin
      r_out  <= bus.load_data;
      r_cnt  <= '0;
      r_step <= 1'b0;
`ifdef LPS_BOUNCE_EN
      r_dir  <= bus.l_rn;
      r_edge <= 1'b0;
`endif
    end else begin
      r_step <= w_step;
`ifdef LPS_BOUNCE_EN
      r_edge <= w_step && w_edge;
`endif
      if (w_step) begin
        r_out <= w_next;
        r_cnt <= '0;
`ifdef LPS_BOUNCE_EN
        r_dir <= w_dir_next;
`endif
      end else if (bus.ena) begin
        r_cnt <= r_cnt + PRESC_W'(1);
      end
    end
  end

  assign bus.out  = r_out;
  assign bus.step = r_step;
`ifdef LPS_BOUNCE_EN
  assign bus.edge_hit = r_edge;
`else
  assign bus.edge_hit = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_light_pattern_shifter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_light_pattern_shifter                                                 |
// | Directed vector table plus an async reset sequence for the LED engine.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_light_pattern_shifter;

  typedef struct {
    logic       load;
    logic [7:0] ld;
    logic       ena;
    logic [1:0] mode;
    logic       l_rn;
    logic       fill;
    logic [3:0] div;
    logic [7:0] eo;
    logic       es;
    logic       ee;
  } vec_t;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  int   total  = 0;
  int   passed = 0;
  vec_t vecs[128];
  int   nv = 0;

  light_pattern_shifter_if #(.WIDTH(8), .PRESC_W(4)) bus ();

  light_pattern_shifter #(.WIDTH(8), .PRESC_W(4), .RESET_PAT(8'h01)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic add(input logic load, input logic [7:0] ld, input logic ena,
                     input logic [1:0] mode, input logic l_rn, input logic fill,
                     input logic [3:0] div, input logic [7:0] eo, input logic es,
                     input logic ee);
    vecs[nv] = '{load, ld, ena, mode, l_rn, fill, div, eo, es, ee};
    nv++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    bus.load      = v.load;
    bus.load_data = v.ld;
    bus.ena       = v.ena;
    bus.mode      = v.mode;
    bus.l_rn      = v.l_rn;
    bus.fill      = v.fill;
    bus.div       = v.div;
  endtask

  initial begin
    logic [7:0] pat;
    vec_t idle;
    idle = '{1'b0, 8'h00, 1'b0, 2'b01, 1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0};
    drive(idle);

    // Rotate left, div 0: 02..80 then 01
    pat = 8'h01;
    for (int i = 0; i < 8; i++) begin
      pat = {pat[6:0], pat[7]};
      add(0, 8'h00, 1, 2'b01, 1, 0, 4'd0, pat, 1, 0);
    end
    // Shift left fill 1 from 00, then fill 0 rightward
    add(1, 8'h00, 1, 2'b10, 1, 1, 4'd0, 8'h00, 0, 0);
    pat = 8'h00;
    for (int i = 0; i < 8; i++) begin
      pat = {pat[6:0], 1'b1};
      add(0, 8'h00, 1, 2'b10, 1, 1, 4'd0, pat, 1, 0);
    end
    add(0, 8'h00, 1, 2'b10, 0, 0, 4'd0, 8'h7F, 1, 0);
    add(0, 8'h00, 1, 2'b10, 0, 0, 4'd0, 8'h3F, 1, 0);
    // Load beats a due step; next step rotates the loaded value; hold still pulses
    add(1, 8'hA5, 1, 2'b01, 1, 0, 4'd0, 8'hA5, 0, 0);
    add(0, 8'h00, 1, 2'b01, 1, 0, 4'd0, 8'h4B, 1, 0);
    add(0, 8'h00, 1, 2'b00, 1, 0, 4'd0, 8'h4B, 1, 0);
    add(1, 8'h5A, 0, 2'b01, 1, 0, 4'd0, 8'h5A, 0, 0);
    add(0, 8'h00, 0, 2'b01, 1, 0, 4'd0, 8'h5A, 0, 0);
    // Prescaler div 3, rotate right, ena low 4 cycles mid-period
    add(1, 8'h01, 1, 2'b01, 0, 0, 4'd3, 8'h01, 0, 0);
    add(0, 8'h00, 1, 2'b01, 0, 0, 4'd3, 8'h01, 0, 0);
    add(0, 8'h00, 1, 2'b01, 0, 0, 4'd3, 8'h01, 0, 0);
    add(0, 8'h00, 1, 2'b01, 0, 0, 4'd3, 8'h01, 0, 0);
    add(0, 8'h00, 1, 2'b01, 0, 0, 4'd3, 8'h80, 1, 0);
    add(0, 8'h00, 1, 2'b01, 0, 0, 4'd3, 8'h80, 0, 0);
    add(0, 8'h00, 1, 2'b01, 0, 0, 4'd3, 8'h80, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 8'h00, 0, 2'b01, 0, 0, 4'd3, 8'h80, 0, 0);
    add(0, 8'h00, 1, 2'b01, 0, 0, 4'd3, 8'h80, 0, 0);
    add(0, 8'h00, 1, 2'b01, 0, 0, 4'd3, 8'h40, 1, 0);
    // Lowering div below the running count steps immediately
    add(1, 8'h01, 1, 2'b01, 1, 0, 4'd3, 8'h01, 0, 0);
    add(0, 8'h00, 1, 2'b01, 1, 0, 4'd3, 8'h01, 0, 0);
    add(0, 8'h00, 1, 2'b01, 1, 0, 4'd3, 8'h01, 0, 0);
    add(0, 8'h00, 1, 2'b01, 1, 0, 4'd1, 8'h02, 1, 0);
    add(0, 8'h00, 1, 2'b01, 1, 0, 4'd1, 8'h02, 0, 0);
    add(0, 8'h00, 1, 2'b01, 1, 0, 4'd1, 8'h04, 1, 0);
    // Mode 11 from load 40, l_rn 1
    add(1, 8'h40, 1, 2'b11, 1, 0, 4'd0, 8'h40, 0, 0);
`ifdef LPS_BOUNCE_EN
    add(0, 8'h00, 1, 2'b11, 1, 0, 4'd0, 8'h80, 1, 0);
    add(0, 8'h00, 1, 2'b11, 1, 0, 4'd0, 8'h40, 1, 1);
    pat = 8'h40;
    for (int i = 0; i < 6; i++) begin
      pat = {1'b0, pat[7:1]};
      add(0, 8'h00, 1, 2'b11, 1, 0, 4'd0, pat, 1, 0);
    end
    add(0, 8'h00, 1, 2'b11, 1, 0, 4'd0, 8'h02, 1, 1);
    add(1, 8'h00, 1, 2'b11, 0, 0, 4'd0, 8'h00, 0, 0);
    add(0, 8'h00, 1, 2'b11, 0, 0, 4'd0, 8'h00, 1, 0);
    add(0, 8'h00, 1, 2'b11, 0, 0, 4'd0, 8'h00, 1, 0);
`else
    pat = 8'h40;
    for (int i = 0; i < 9; i++) begin
      pat = {pat[6:0], pat[7]};
      add(0, 8'h00, 1, 2'b11, 1, 0, 4'd0, pat, 1, 0);
    end
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out", {24'h0, bus.out}, 32'h01);
    chk("reset_step", {31'h0, bus.step}, 32'h0);
    chk("reset_edge", {31'h0, bus.edge_hit}, 32'h0);
    nrst = 1'b1;

    for (int i = 0; i < nv; i++) begin
      drive(vecs[i]);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_out", i), {24'h0, bus.out}, {24'h0, vecs[i].eo});
      chk($sformatf("v%0d_step", i), {31'h0, bus.step}, {31'h0, vecs[i].es});
      chk($sformatf("v%0d_edge", i), {31'h0, bus.edge_hit}, {31'h0, vecs[i].ee});
    end

    // Async reset between edges while stepping every cycle
    drive('{1'b1, 8'h10, 1'b1, 2'b01, 1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    bus.load = 1'b0;
    @(posedge clk);
    #1;
    chk("pre_rst_out", {24'h0, bus.out}, 32'h20);
    chk("pre_rst_step", {31'h0, bus.step}, 32'h1);
    #2;
    nrst = 1'b0;
    #1;
    chk("async_rst_out", {24'h0, bus.out}, 32'h01);
    chk("async_rst_step", {31'h0, bus.step}, 32'h0);
    bus.div = 4'd2;
    #2;
    nrst = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post_rst_c%0d_out", c), {24'h0, bus.out}, (c == 3) ? 32'h02 : 32'h01);
      chk($sformatf("post_rst_c%0d_step", c), {31'h0, bus.step}, (c == 3) ? 32'h1 : 32'h0);
    end

    drive(idle);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/light_pattern_shifter.md
# light_pattern_shifter

Parametrised LED pattern engine for the light-shifting designs and the successor to the fixed 8-bit left/right shift register. It holds a WIDTH-bit light pattern and advances it once per programmable prescaler period in one of four modes: hold, rotate, shift-with-fill, or bounce (ping-pong). It also supports a synchronous pattern load. The `out` bus drives the board LEDs directly.

## Interface
- `WIDTH`, 8: pattern width in bits (≥2).
- `PRESC_W`, 4: width of the prescaler divider and counter.
- `RESET_PAT`, 1: value of `out` after reset (WIDTH bits).
- `clk`  in  1  system clock; all state updates on the rising edge.
- `nrst`  in  1  asynchronous, active-low reset.
- `ena`  in  1  enables the prescaler and stepping; when low, all state holds (`load` still works).
- `mode`  in  2  00 hold, 01 rotate, 10 shift-with-fill, 11 bounce.
- `l_rn`  in  1  direction: 1 = left (toward MSB), 0 = right. Used by modes 01 and 10; copied into the bounce direction register on `load`.
- `fill`  in  1  bit shifted in by mode 10.
- `div`  in  PRESC_W  step period minus 1. 0 = step every enabled cycle.
- `load`  in  1  synchronous load of `load_data`.
- `load_data`  in  WIDTH  pattern to load.
- `out`  out  WIDTH  current light pattern (registered).
- `step`  out  1  registered pulse; high for the cycle in which `out` shows a freshly stepped value.
- `edge_hit`  out  1  registered pulse; high with `step` when bounce mode reversed direction on that step.

## Operation
- State:
  - `out` register.
  - Prescaler counter `cnt` (PRESC_W bits).
  - Bounce direction register `dir` (1 = left).
- Reset (async, `nrst`=0):
  - `out`=RESET_PAT, `cnt`=0, `dir`=1, `step`=0, `edge_hit`=0.
- Priority per edge: reset > `load` > step > hold.
- `load`=1:
  - `out`←`load_data`, `cnt`←0, `dir`←`l_rn`.
  - `step`=0 and `edge_hit`=0 next cycle. This applies regardless of `ena`.
- Step condition: `ena`=1 and `cnt`≥`div`. Using ≥ means that lowering `div` below `cnt` never stalls the counter.
  - On a step edge: `cnt`←0.
  - Otherwise, with `ena`=1: `cnt`←`cnt`+1.
  - With `ena`=0: `cnt` holds.
- Mode actions on a step edge:
  - 00 hold: `out` unchanged. `step` still pulses.
  - 01 rotate:
    - Left: `out`←{`out`[W-2:0], `out`[W-1]}.
    - Right: `out`←{`out`[0], `out`[W-1:1]}.
  - 10 shift:
    - Left: `out`←{`out`[W-2:0], `fill`}.
    - Right: `out`←{`fill`, `out`[W-1:1]}.
  - 11 bounce:
    - If `dir`=1 and `out`[W-1]=1: `dir`←0, shift right (zero fill), `edge_hit` pulses.
    - Else if `dir`=0 and `out`[0]=1: `dir`←1, shift left (zero fill), `edge_hit` pulses.
    - Else: shift one position in direction `dir`, zero fill.
    - An all-zero pattern stays all-zero and never hits an edge.
- `mode` or `l_rn` changes take effect on the next step and do not disturb `cnt`.
- `dir` changes only on a bounce reversal or on `load`.

## Timing
- Step period is `div`+1 enabled cycles.
- `out`, `step` and `edge_hit` all update on the same edge. Output latency is 0 cycles after the qualifying edge.
- `step` is never high for two consecutive cycles unless `div`=0 and `ena` stays high.
- When `ena` falls, stepping stops from that edge onward. When `ena` rises, counting resumes from the held `cnt`.
- Reset asserted mid-period discards the partial count. The first step after release occurs `div`+1 enabled cycles later.

## Configuration
- `LPS_BOUNCE_EN` defined:
  - Bounce mode, the `dir` register and `edge_hit` are implemented as described.
- Not defined:
  - Mode 11 behaves exactly as mode 01 (rotate using `l_rn`).
  - The `dir` register is absent.
  - `edge_hit` is tied to 0.

## Test plan
- Rotate, left, `div`=0, RESET_PAT=1, `ena`=1 after reset:
  - `out` reads 02, 04, … 80, then 01 on the 8th step.
  - `step` is high every cycle.
- Prescaler, `div`=3, rotate right, with `ena` dropped for 4 cycles mid-period:
  - `out` changes exactly every 4 enabled cycles.
  - No change while `ena`=0.
  - Count resumes from the held value.
- Shift left, `fill`=1, from 00:
  - Sequence 01, 03, 07, … FF.
  - Then `fill`=0 and `l_rn`=0 gives 7F, 3F, …
- Bounce (`LPS_BOUNCE_EN`), load 40 with `l_rn`=1, `div`=0:
  - Sequence 80 (no edge), 40 with `edge_hit`=1, 20, … 01, 02 with `edge_hit`=1.
  - Without the macro, the same stimulus rotates: 80, 01.
- `load`=1 and a step in the same cycle with `load_data`=A5:
  - `out`=A5, `step`=0, `cnt`=0.
- Async `nrst` pulse between clock edges mid-sequence:
  - `out`=01 and `step`=0 immediately, without waiting for a clock edge.
  - After release, the first step occurs after `div`+1 cycles.
